// File: rtl/mul163_ctrl.sv
// mul163_ctrl: sequencer for a digit-serial GF(2^163) multiplier array.
// Feeds B one digit per cycle (MSD first), drains the array, latches the product.
module mul163_ctrl #(
   parameter int DIGITS = 32,
   parameter int M      = 163,
   parameter int NDIG   = 6,
   parameter int PIPE   = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic [M-1:0]           a_in,
   input  logic [M-1:0]           b_in,
   output logic                   busy,
   output logic                   done,
   output logic [M-1:0]           c_out,
   output logic [DIGITS*NDIG-1:0] pe_a,
   output logic                   pe_clr,
   output logic                   pe_en,
   output logic [DIGITS-1:0]      pe_b_digit,
   output logic                   pe_last,
   input  logic [M-1:0]           pe_result
);

   localparam int W  = DIGITS * NDIG;
   localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int PW = (PIPE > 1) ? $clog2(PIPE) : 1;
   localparam int PL = (PIPE > 0) ? PIPE - 1 : 0;

   localparam logic [CW-1:0] CNT_TOP  = CW'(NDIG - 1);
   localparam logic [PW-1:0] PIPE_TOP = PW'(PL);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t         state;
   state_t         state_nx;
   logic [M-1:0]   a_reg;
   logic [M-1:0]   b_reg;
   logic [M-1:0]   c_reg;
   logic [CW-1:0]  dig_cnt;
   logic [PW-1:0]  pipe_cnt;
   logic [W-1:0]   b_ext;
   logic           accept;
   logic           run_end;
   logic           drain_end;

   // abort beats start, so a simultaneous pair in IDLE never launches
   assign accept    = (state == IDLE) && start && !abort;
   assign run_end   = (dig_cnt == '0);
   assign drain_end = (pipe_cnt == PIPE_TOP);
   assign b_ext     = W'(b_reg);

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next-state logic; abort overrides every non-idle transition
   always_comb begin
      state_nx = state;
      if (abort && state != IDLE) begin
         state_nx = IDLE;
      end else begin
         unique case (state)
            IDLE:    if (accept) state_nx = LOAD;
            LOAD:    state_nx = RUN;
            RUN: begin
               if (run_end) begin
                  state_nx = (PIPE == 0) ? DONE : DRAIN;
               end
            end
            DRAIN:   if (drain_end) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   // operands are captured only when an operation is accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg <= '0;
         b_reg <= '0;
      end else if (accept) begin
         a_reg <= a_in;
         b_reg <= b_in;
      end
   end

   // digit index: preset in LOAD, counts down in RUN, parks at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dig_cnt <= '0;
      end else if (state == LOAD) begin
         dig_cnt <= CNT_TOP;
      end else if (state == RUN && !run_end) begin
         dig_cnt <= dig_cnt - CW'(1);
      end
   end

   // drain timer runs only while in DRAIN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_cnt <= '0;
      end else if (state == DRAIN) begin
         pipe_cnt <= pipe_cnt + PW'(1);
      end else begin
         pipe_cnt <= '0;
      end
   end

   // result register keeps the last completed product between operations
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_reg <= '0;
      end else if (state == DONE && !abort) begin
         c_reg <= pe_result;
      end
   end

   // output decode; c_out forwards pe_result in DONE so it is valid with done
   always_comb begin
      busy       = 1'b0;
      done       = 1'b0;
      pe_clr     = 1'b0;
      pe_en      = 1'b0;
      pe_last    = 1'b0;
      pe_b_digit = '0;
      pe_a       = W'(a_reg);
      unique case (state)
         IDLE: begin
            busy = 1'b0;
         end
         LOAD: begin
            busy   = 1'b1;
            pe_clr = 1'b1;
         end
         RUN: begin
            busy       = 1'b1;
            pe_en      = 1'b1;
            pe_last    = run_end;
            pe_b_digit = DIGITS'(b_ext >> (DIGITS * int'(dig_cnt)));
         end
         DRAIN: begin
            busy = 1'b1;
         end
         DONE: begin
            busy = 1'b1;
            done = !abort;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
      if (abort && state != IDLE) pe_clr = 1'b1;
      c_out = done ? pe_result : c_reg;
   end

endmodule

// File: tb/tb_mul163_ctrl.sv
// tb_mul163_ctrl: directed checks of the multiplier sequencer.
// Default build drives a GF(2^163) array model; two reduced builds check timing.
module tb_mul163_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         abort;
   logic [162:0] a;
   logic [162:0] b;

   logic         busy, done, pe_clr, pe_en, pe_last;
   logic [162:0] c_out, pe_result;
   logic [191:0] pe_a;
   logic [31:0]  pe_b_digit;

   logic         busy0, done0, clr0, en0, last0;
   logic [162:0] c0;
   logic [191:0] pa0;
   logic [31:0]  dig0;

   logic         busy1, done1, clr1, en1, last1;
   logic [162:0] c1, pa1, dig1;

   logic [162:0] acc, res_q;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mul163_ctrl u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .a_in(a), .b_in(b), .busy(busy), .done(done),
      .c_out(c_out), .pe_a(pe_a), .pe_clr(pe_clr),
      .pe_en(pe_en), .pe_b_digit(pe_b_digit),
      .pe_last(pe_last), .pe_result(pe_result)
   );

   mul163_ctrl #(.PIPE(0)) u_p0 (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .a_in(a), .b_in(b), .busy(busy0), .done(done0),
      .c_out(c0), .pe_a(pa0), .pe_clr(clr0),
      .pe_en(en0), .pe_b_digit(dig0),
      .pe_last(last0), .pe_result(163'h5A)
   );

   mul163_ctrl #(.DIGITS(163), .NDIG(1)) u_n1 (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .a_in(a), .b_in(b), .busy(busy1), .done(done1),
      .c_out(c1), .pe_a(pa1), .pe_clr(clr1),
      .pe_en(en1), .pe_b_digit(dig1),
      .pe_last(last1), .pe_result(163'h3C)
   );

   // acc <- acc * x^32 + a * digit, mod x^163 + x^7 + x^6 + x^3 + 1
   function automatic logic [162:0] step(
      input logic [162:0] s,
      input logic [162:0] x,
      input logic [31:0]  d
   );
      logic [162:0] r;
      r = s;
      for (int i = 31; i >= 0; i--) begin
         r = {r[161:0], 1'b0} ^ (r[162] ? 163'hC9 : 163'h0);
         if (d[i]) r = r ^ x;
      end
      return r;
   endfunction

   // array model: clear wins over enable, one output register stage
   always @(posedge clk) begin
      if (pe_clr)     acc <= '0;
      else if (pe_en) acc <= step(acc, pe_a[162:0], pe_b_digit);
      res_q <= acc;
   end
   assign pe_result = res_q;

   task automatic chk(
      input string        tag,
      input logic [191:0] obs,
      input logic [191:0] exp
   );
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      a     = '0;
      b     = '0;
      #3;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_en", pe_en, 0);
      chk("rst_last", pe_last, 0);
      chk("rst_clr", pe_clr, 0);
      chk("rst_digit", pe_b_digit, 0);
      chk("rst_pe_a", pe_a, 0);
      chk("rst_c_out", c_out, 0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // basic a=1, b=1 on all three builds
      a = 163'd1;
      b = 163'd1;
      start = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         tick();
         start = 1'b0;
         chk("b_busy", busy, c <= 10);
         chk("b_done", done, c == 10);
         chk("b_en", pe_en, c >= 2 && c <= 7);
         chk("b_clr", pe_clr, c == 1);
         chk("b_last", pe_last, c == 7);
         chk("b_digit", pe_b_digit, (c == 7) ? 1 : 0);
         chk("b_pe_a", pe_a, 1);
         chk("p0_done", done0, c == 8);
         chk("n1_done", done1, c == 5);
         chk("n1_last", last1, c == 2);
         if (c == 10) chk("b_c_out", c_out, 1);
         if (c == 11) chk("b_c_hold", c_out, 1);
         if (c == 8)  chk("p0_c_out", c0, 163'h5A);
         if (c == 5)  chk("n1_c_out", c1, 163'h3C);
      end

      // abort with start in IDLE: not accepted
      a = 163'd9;
      abort = 1'b1;
      start = 1'b1;
      #1;
      chk("idle_abort_clr", pe_clr, 0);
      tick();
      chk("idle_abort_busy", busy, 0);
      chk("idle_abort_pe_a", pe_a, 1);
      abort = 1'b0;
      start = 1'b0;
      tick();

      // reduction: x * x^162 = x^163 = 0xC9
      a = 163'd2;
      b = '0;
      b[162] = 1'b1;
      start = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         tick();
         start = 1'b0;
         if (c == 2) chk("r_top_digit", pe_b_digit, 32'h4);
         if (c == 3) chk("r_digit4", pe_b_digit, 0);
         if (c == 10) chk("r_done", done, 1);
         if (c == 10) chk("r_c_out", c_out, 163'hC9);
      end

      // back-to-back with start held: (x+1)(x^2+1) = 0xF
      a = 163'd3;
      b = 163'd5;
      start = 1'b1;
      for (int c = 1; c <= 22; c++) begin
         tick();
         chk("bb_done", done, c == 10 || c == 21);
         chk("bb_busy", busy, !(c == 11 || c == 22));
         if (c == 21) chk("bb_c_out", c_out, 163'hF);
      end
      start = 1'b0;
      tick();
      chk("bb_idle", busy, 0);

      // abort in RUN at cycle 5, restart at cycle 7
      a = 163'd1;
      b = 163'd1;
      start = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         tick();
         start = 1'b0;
         if (c == 5) begin
            abort = 1'b1;
            #1;
            chk("ab_clr", pe_clr, 1);
            chk("ab_done", done, 0);
         end
         if (c == 6) begin
            abort = 1'b0;
            chk("ab_idle", busy, 0);
            chk("ab_clr_off", pe_clr, 0);
            chk("ab_c_keep", c_out, 163'hF);
         end
      end
      a = 163'd4;
      b = 163'd8;
      start = 1'b1;
      for (int c = 8; c <= 17; c++) begin
         tick();
         start = 1'b0;
         chk("rs_done", done, c == 17);
         chk("rs_c_out", c_out, (c == 17) ? 163'h20 : 163'hF);
      end
      tick();

      // async reset in the middle of DRAIN
      a = 163'd7;
      b = 163'd1;
      start = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         start = 1'b0;
      end
      chk("ar_drain_busy", busy, 1);
      chk("ar_drain_en", pe_en, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_busy", busy, 0);
      chk("ar_done", done, 0);
      chk("ar_clr", pe_clr, 0);
      chk("ar_pe_a", pe_a, 0);
      chk("ar_c_out", c_out, 0);
      @(negedge clk);
      rst = 1'b0;
      a = 163'd1;
      b = 163'd6;
      start = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         tick();
         start = 1'b0;
         if (c == 1) chk("ar_first_edge", busy, 1);
         chk("ar_new_done", done, c == 10);
         if (c == 10) chk("ar_new_c", c_out, 163'h6);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
